// File: rtl/uart_wrapper.sv
// UART command receiver (two bytes -> 16-bit cmd, high byte first) and response byte transmitter.
// Optional build macro UART_WRAPPER_FRAME_ERR_EN: drop bytes whose stop bit samples low.
module uart_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

    localparam logic [0:0] ST_HIGH = 1'b0;
    localparam logic [0:0] ST_LOW  = 1'b1;

    // ---------------- RX synchronizer and edge detect ----------------
    logic rx_s1_q, rx_s1_d;
    logic rx_s2_q, rx_s2_d;
    logic rx_prev_q, rx_prev_d;
    logic rx_fall;

    always_comb begin
        rx_s1_d   = RX;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    // ---------------- RX deserializer ----------------
    logic          rx_busy_q, rx_busy_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_stop;
    logic          rx_rdy;

    // rx_bit counts samples: 0 = start, 1..8 = data, 9 = stop.
    always_comb begin
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_stop    = 1'b0;
        if (!rx_busy_q) begin
            if (rx_fall) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = HALF_M1;
                rx_bit_d  = 4'd0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
            rx_cnt_d = FULL_M1;
            if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                rx_bit_d  = 4'd0;
                rx_stop   = 1'b1;
            end else begin
                rx_bit_d = rx_bit_q + 4'd1;
                if (rx_bit_q != 4'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

`ifdef UART_WRAPPER_FRAME_ERR_EN
    logic rx_ferr;
    assign rx_rdy  = rx_stop & rx_s2_q;
    assign rx_ferr = rx_stop & ~rx_s2_q;
`else
    assign rx_rdy  = rx_stop;
`endif

    // ---------------- Command assembly FSM ----------------
    logic [0:0]  state_q, state_d;
    logic [7:0]  upper_q, upper_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    // Set of cmd_rdy is evaluated after the clear so that set wins.
    always_comb begin
        state_d   = state_q;
        upper_d   = upper_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (state_q)
            ST_HIGH: begin
                if (rx_rdy) begin
                    upper_d   = rx_shift_q;
                    cmd_rdy_d = 1'b0;
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rx_rdy) begin
                    cmd_d     = {upper_q, rx_shift_q};
                    cmd_rdy_d = 1'b1;
                    state_d   = ST_HIGH;
                end
`ifdef UART_WRAPPER_FRAME_ERR_EN
                else if (rx_ferr) begin
                    upper_d = 8'h00;
                    state_d = ST_HIGH;
                end
`endif
            end
            default: state_d = ST_HIGH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HIGH;
            upper_q   <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            upper_q   <= upper_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // ---------------- TX serializer ----------------
    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          tx_done_q, tx_done_d;

    // Shift fills with ones so the line idles high once the stop bit is out.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done_d  = tx_done_q;
        if (!tx_busy_q) begin
            if (trmt) begin
                tx_busy_d  = 1'b1;
                tx_shift_d = {1'b1, resp, 1'b0};
                tx_cnt_d   = '0;
                tx_bit_d   = 4'd0;
                tx_done_d  = 1'b0;
            end
        end else if (tx_cnt_q != FULL_M1) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
                tx_bit_d  = 4'd0;
                tx_done_d = 1'b1;
            end else begin
                tx_bit_d = tx_bit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 10'h3FF;
            tx_done_q  <= 1'b0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Scoreboard bench for uart_wrapper: commands pushed on send, popped on each cmd_rdy rising edge.
module tb_uart_wrapper;

    localparam int BAUD = 16;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cmd_exp_q[$];
    logic        tx_exp_q[$];
    logic        cmd_rdy_prev;

    uart_wrapper #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .trmt        (trmt),
        .resp        (resp),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every fresh cmd_rdy edge must match the oldest sent command.
    always @(negedge clk) begin
        if (!rst && cmd_rdy && !cmd_rdy_prev) begin
            if (cmd_exp_q.size() == 0) begin
                check("cmd_unexpected", 16'd1, 16'd0);
            end else begin
                check("cmd_value", cmd, cmd_exp_q.pop_front());
            end
        end
        cmd_rdy_prev <= cmd_rdy;
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4 * BAUD && cmd_exp_q.size() != 0; i++) @(negedge clk);
        if (cmd_exp_q.size() != 0) begin
            check(tag, 16'(cmd_exp_q.size()), 16'd0);
            cmd_exp_q.delete();
        end
    endtask

    task automatic send_cmd(input logic [15:0] c, input string tag);
        cmd_exp_q.push_back(c);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        wait_drain(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] tx_frame;
        rst          = 1'b1;
        RX           = 1'b1;
        clr_cmd_rdy  = 1'b0;
        trmt         = 1'b0;
        resp         = 8'h00;
        cmd_rdy_prev = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
        check("rst_tx", 16'(TX), 16'd1);
        check("rst_tx_done", 16'(tx_done), 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // First command, then explicit clear
        send_cmd(16'hF00F, "drain_f00f");
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("clr_cmd_rdy", 16'(cmd_rdy), 16'd0);
        check("clr_cmd_hold", cmd, 16'hF00F);

        send_cmd(16'h596A, "drain_596a");
        check("rdy_before_af", 16'(cmd_rdy), 16'd1);

        // Uncleared: upper byte arrival must drop cmd_rdy
        cmd_exp_q.push_back(16'hAF50);
        send_byte(8'hAF);
        check("auto_clear", 16'(cmd_rdy), 16'd0);
        send_byte(8'h50);
        wait_drain("drain_af50");

        // TX frame; a second trmt mid-frame must be ignored
        resp     = 8'hA5;
        tx_frame = {1'b1, resp, 1'b0};
        for (int i = 0; i < 10; i++) tx_exp_q.push_back(tx_frame[i]);
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        resp = 8'h00;
        repeat (BAUD / 2 - 1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), 16'(TX), 16'(tx_exp_q.pop_front()));
            if (i == 0) check("tx_done_busy", 16'(tx_done), 16'd0);
            if (i == 4) begin
                trmt = 1'b1;
                @(negedge clk);
                trmt = 1'b0;
                repeat (BAUD - 1) @(negedge clk);
            end else begin
                repeat (BAUD) @(negedge clk);
            end
        end
        begin
            int k;
            for (k = 0; k < 2 * BAUD && !tx_done; k++) @(negedge clk);
        end
        check("tx_done", 16'(tx_done), 16'd1);
        check("tx_idle", 16'(TX), 16'd1);

        // Reset after only the upper byte: it must not leak into the next command
        send_byte(8'h77);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_cmd", cmd, 16'h0000);
        check("abort_cmd_rdy", 16'(cmd_rdy), 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(16'h1234, "drain_1234");
        check("final_cmd", cmd, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
